uart_rx: RTL and testbench

//  UART receiver, 8N1, LSB first. Counterpart of the team's uart_tx on the same serial link.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a runtime-programmable bit time.
// The RX line is synchronized, sampled at mid-bit by a down-counting bit timer,
// and each good byte is delivered through a valid/ack holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        RX,
  input  logic [20:0] prescaler_in,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_frame_err,
  output logic        rx_overrun,
  output logic        rx_active
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [20:0]            p_clamped;
  logic [20:0]            p_q;
  logic [20:0]            cnt;
  logic [2:0]             state;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   sample;
  logic                   stop_sample;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign p_clamped   = (prescaler_in < 21'd4) ? 21'd4 : prescaler_in;
  assign sample      = (cnt == 21'd0);
  assign stop_sample = (state == ST_STOP) && sample;
  assign rx_active   = (state != ST_IDLE);

  // Shift the asynchronous RX line through a chain of flops that idle high
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end
  end

  // Frame FSM with bit timer: half a bit to reach mid-start, then one full bit per sample
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      p_q     <= 21'd4;
      cnt     <= 21'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (state == ST_IDLE) begin
        p_q <= p_clamped;
      end
      if (state != ST_IDLE) begin
        if (sample) begin
          cnt <= p_q - 21'd1;
        end else begin
          cnt <= cnt - 21'd1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            cnt     <= p_clamped >> 1;
            bit_idx <= 3'd0;
          end
        end
        ST_START: begin
          if (sample) begin
            state <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (sample) begin
            state <= rx_s ? ST_IDLE : ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register: load on a good stop bit, clear on ack, pulse error flags
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (stop_sample && rx_s) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (stop_sample && !rx_s) begin
        rx_frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames onto RX with a behavioural transmitter and
// compares delivered bytes, flag pulses and latency against expectations
// derived from the frame contents and bit time.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic        CLK;
  logic        rst_n;
  logic        RX;
  logic [20:0] prescaler_in;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cnt = 0;
  int last_rise_cyc = 0;
  int frame_t0 = 0;
  logic valid_d = 1'b0;
  bit auto_ack = 1'b0;
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .RX(RX),
    .prescaler_in(prescaler_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun),
    .rx_active(rx_active)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter used to time frames and latency
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor counting flag pulses and rx_valid rising edges
  always @(negedge CLK) begin
    if (rx_frame_err) fe_cnt++;
    if (rx_overrun) ov_cnt++;
    if (rx_valid && !valid_d) begin
      rise_cnt++;
      last_rise_cyc = cyc;
    end
    valid_d = rx_valid;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkLatency(input string tag, input int p);
    int meas;
    int req;
    meas = last_rise_cyc - frame_t0;
    req = SYNC + (p >> 1) + 9 * p + 1;
    checks++;
    assert (meas >= req - 1 && meas <= req + 1) else begin
      errors++;
      $error("[TB] FAIL %s latency=%0d required=%0d+/-1", tag, meas, req);
    end
  endtask

  task automatic service();
    if (auto_ack) begin
      if (rx_valid && !rx_ack) begin
        got_q.push_back(rx_data);
        rx_ack = 1'b1;
      end else begin
        rx_ack = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int p,
                               input int ack_offset);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (b == 0 && c == 0) frame_t0 = cyc;
        if (c == 0) RX = frame[b];
        if (ack_offset >= 0) rx_ack = (cyc == frame_t0 + ack_offset);
        service();
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      service();
    end
  endtask

  task automatic ackNow();
    @(negedge CLK);
    rx_ack = 1'b1;
    @(negedge CLK);
    rx_ack = 1'b0;
  endtask

  initial begin
    int fe0;
    int ov0;
    int rise0;
    int p;
    logic [7:0] b;
    logic [7:0] last_good;
    logic [9:0] pframe;

    rst_n = 1'b0;
    RX = 1'b1;
    rx_ack = 1'b0;
    prescaler_in = 21'd16;

    // Reset state
    repeat (3) @(negedge CLK);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_frame_err", rx_frame_err, 1'b0);
    checkOutput("reset_overrun", rx_overrun, 1'b0);
    checkOutput("reset_active", rx_active, 1'b0);
    rst_n = 1'b1;
    idleCycles(5);

    // Single byte, latency and ack
    $display("[TB] single byte 0xA5 at P=16");
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    applyStimulus(8'hA5, 1'b1, 16, -1);
    idleCycles(4);
    checkOutput("t1_data", rx_data, 8'hA5);
    checkOutput("t1_valid", rx_valid, 1'b1);
    checkLatency("t1_latency", 16);
    checkOutput("t1_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    ackNow();
    checkOutput("t1_ack_clears", rx_valid, 1'b0);

    // Random back-to-back bytes with auto ack, then random bit times
    $display("[TB] random back-to-back bytes");
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    sent_q.delete();
    got_q.delete();
    auto_ack = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      applyStimulus(b, 1'b1, 16, -1);
    end
    idleCycles(10);
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(4, 40);
      prescaler_in = 21'(p);
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      applyStimulus(b, 1'b1, p, -1);
    end
    idleCycles(10);
    auto_ack = 1'b0;
    prescaler_in = 21'd16;
    checkOutput("t2_count", got_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      checkOutput($sformatf("t2_byte%0d", i), got_q[i], sent_q[i]);
    end
    checkOutput("t2_frame_err", fe_cnt - fe0, 0);
    checkOutput("t2_overrun", ov_cnt - ov0, 0);
    last_good = sent_q[sent_q.size() - 1];

    // Short glitch on an idle line
    $display("[TB] start-bit glitch");
    fe0 = fe_cnt;
    rise0 = rise_cnt;
    @(negedge CLK);
    RX = 1'b0;
    idleCycles(5);
    checkOutput("t3_active_during", rx_active, 1'b1);
    @(negedge CLK);
    RX = 1'b1;
    idleCycles(40);
    checkOutput("t3_active_after", rx_active, 1'b0);
    checkOutput("t3_valid", rx_valid, 1'b0);
    checkOutput("t3_frame_err", fe_cnt - fe0, 0);
    checkOutput("t3_no_rise", rise_cnt - rise0, 0);

    // Framing error followed by a stuck-low line
    $display("[TB] framing error and break");
    fe0 = fe_cnt;
    rise0 = rise_cnt;
    applyStimulus(8'h3C, 1'b0, 16, -1);
    idleCycles(500);
    checkOutput("t4_one_frame_err", fe_cnt - fe0, 1);
    checkOutput("t4_valid", rx_valid, 1'b0);
    checkOutput("t4_data_kept", rx_data, last_good);
    checkOutput("t4_wait_high", rx_active, 1'b1);
    @(negedge CLK);
    RX = 1'b1;
    idleCycles(20);
    checkOutput("t4_idle_again", rx_active, 1'b0);
    applyStimulus(8'h55, 1'b1, 16, -1);
    idleCycles(5);
    checkOutput("t4_next_data", rx_data, 8'h55);
    checkOutput("t4_next_valid", rx_valid, 1'b1);
    checkOutput("t4_frame_err_total", fe_cnt - fe0, 1);
    ackNow();
    checkOutput("t4_ack_clears", rx_valid, 1'b0);

    // Overrun, then ack coinciding with completion
    $display("[TB] overrun and coincident ack");
    ov0 = ov_cnt;
    applyStimulus(8'h11, 1'b1, 16, -1);
    applyStimulus(8'h22, 1'b1, 16, -1);
    idleCycles(4);
    checkOutput("t5_overrun_once", ov_cnt - ov0, 1);
    checkOutput("t5_data", rx_data, 8'h22);
    checkOutput("t5_valid", rx_valid, 1'b1);
    // Ack lands on the stop-sample edge: one extra cycle for start detection
    applyStimulus(8'h33, 1'b1, 16, SYNC + 1 + 8 + 9 * 16);
    idleCycles(4);
    checkOutput("t5_coinc_no_overrun", ov_cnt - ov0, 1);
    checkOutput("t5_coinc_data", rx_data, 8'h33);
    checkOutput("t5_coinc_valid", rx_valid, 1'b1);

    // Reset in the middle of data bit 4
    $display("[TB] reset mid-frame");
    b = 8'($urandom_range(0, 255));
    pframe = {1'b1, b, 1'b0};
    for (int c = 0; c < 5 * 16 + 8; c++) begin
      @(negedge CLK);
      RX = pframe[c / 16];
    end
    @(negedge CLK);
    rst_n = 1'b0;
    RX = 1'b1;
    #1;
    checkOutput("t6_rst_data", rx_data, 8'h00);
    checkOutput("t6_rst_valid", rx_valid, 1'b0);
    checkOutput("t6_rst_active", rx_active, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("t6_rst_flags", {rx_frame_err, rx_overrun}, 2'b00);
    rst_n = 1'b1;
    idleCycles(5);
    rise0 = rise_cnt;
    applyStimulus(8'h81, 1'b1, 16, -1);
    idleCycles(5);
    checkOutput("t6_data", rx_data, 8'h81);
    checkOutput("t6_valid", rx_valid, 1'b1);
    checkOutput("t6_one_delivery", rise_cnt - rise0, 1);
    ackNow();

    // Prescaler below the minimum behaves as a bit time of 4
    $display("[TB] prescaler clamp");
    prescaler_in = 21'd2;
    idleCycles(3);
    applyStimulus(8'hC3, 1'b1, 4, -1);
    idleCycles(4);
    checkOutput("t7_data", rx_data, 8'hC3);
    checkOutput("t7_valid", rx_valid, 1'b1);
    checkLatency("t7_latency", 4);
    ackNow();
    checkOutput("t7_ack_clears", rx_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
